trigger_delay_queue: RTL and testbench
======================================

TRIGGER_DELAY_QUEUE -- requirements
Module: trigger_delay_queue

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of in-flight triggers held (power of two, 2..64).
REQ-002 Parameter CNT_W, default 32, sets the delay and timestamp width.
REQ-003 Parameter PW_W, default 16, sets the output pulse-width counter width.
REQ-004 Parameter SYNC_STAGES, default 3, sets the input synchroniser depth (2..4).
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 trigger_in  input  1  asynchronous trigger pin.
REQ-008 edge_type  input  2  edge select: 00 rising, 01 falling, 10 both, 11 none; used live.
REQ-009 delay_cycles  input  CNT_W  requested delay; must be at most 2^CNT_W-2.
REQ-010 pulse_width  input  PW_W  requested output high time in cycles; 0 is treated as 1.
REQ-011 cfg_update  input  1  one-cycle strobe that captures delay_cycles and pulse_width into the shadow registers.
REQ-012 arm  input  1  one-cycle strobe that sets armed.
REQ-013 one_shot  input  1  1 = disarm after the first accepted edge; 0 = continuous.
REQ-014 clear_overflow  input  1  one-cycle strobe that clears overflow.
REQ-015 trigger_out  output  1  delayed output pulse, registered.
REQ-016 armed  output  1  edges are accepted while this is high.
REQ-017 pending  output  $clog2(DEPTH)+1  number of queued, unfired triggers.
REQ-018 overflow  output  1  sticky flag: an edge was dropped because the queue was full.
REQ-019 busy  output  1  high when pending is nonzero or trigger_out is high.

Function
REQ-020 The synchroniser and edge detector shall produce a one-cycle edge_pulse for each selected edge of the synchronised trigger_in.
REQ-021 An edge is accepted only if edge_pulse is high and armed is high; all other edges are ignored and not counted.
REQ-022 A free-running CNT_W-bit timestamp counter shall increment every cycle and wrap modulo 2^CNT_W.
REQ-023 Each accepted edge shall push deadline = timestamp + active_delay + 1 (mod 2^CNT_W) into the queue.
REQ-024 The queue head shall pop, and the output shall fire, when the head deadline equals the timestamp; deadlines are compared by equality only, so wrap-around is transparent.
REQ-025 Latency: trigger_out shall rise exactly active_delay+1 cycles after the edge_pulse cycle, for every delay including 0.
REQ-026 The output FSM has states IDLE and PULSE.
REQ-027 In IDLE, a fire event loads the width counter with max(active_width,1), asserts trigger_out and moves to PULSE.
REQ-028 In PULSE, the width counter decrements each cycle and the FSM returns to IDLE with trigger_out low when it expires.
REQ-029 A fire event while in PULSE reloads the width counter, so the pulse is extended and not split.
REQ-030 Queue full with an accepted edge and no pop in the same cycle: the edge is dropped and overflow is set.
REQ-031 Queue full with an accepted edge and a pop in the same cycle: the push succeeds.
REQ-032 If overflow is set and clear_overflow is strobed in the same cycle, set wins.
REQ-033 cfg_update shall write shadow registers; shadow values shall transfer to active_delay/active_width only on a cycle where busy is low and no edge is accepted, keeping queued deadlines monotonic.
REQ-034 armed FSM has states DISARMED and ARMED; arm moves it to ARMED.
REQ-035 In one_shot mode, the first accepted edge moves the armed FSM to DISARMED on the next cycle; if arm coincides with that edge, armed stays high.
REQ-036 In continuous mode, armed stays high once set; it is cleared only by reset.
REQ-037 pending shall increment on a push, decrement on a pop, and stay unchanged on a simultaneous push and pop.

Reset
REQ-038 rst shall asynchronously force trigger_out=0, armed=0, pending=0, overflow=0, busy=0, output FSM=IDLE, timestamp=0 and queue empty.
REQ-039 rst shall set active_delay and shadow delay to 0, and active_width and shadow width to 1.
REQ-040 rst shall clear the synchroniser registers to 0.
REQ-041 Reset mid-pulse or with a non-empty queue shall discard all pending triggers with no output glitch after rst deasserts.

Structure
REQ-042 Shared package trigger_delay_pkg shall hold the edge_type encoding enum, the output FSM state enum and the armed FSM state enum.
REQ-043 Sub-module trigger_deadline_fifo (DEPTH x CNT_W, with full, empty and count) shall hold the deadlines; synchroniser, edge detect and both FSMs stay in the top level.

Verification
REQ-044 Scenario 1: delay=10, width=3, continuous, one rising edge -> trigger_out high for 3 cycles starting 11 cycles after edge_pulse.
REQ-045 Scenario 2: delay=20, DEPTH=4, 5 edges spaced 2 cycles apart -> 4 pulses at their deadlines, 5th edge dropped, overflow=1; clear_overflow -> overflow=0.
REQ-046 Scenario 3: delay=0, width=0 -> a 1-cycle pulse 1 cycle after edge_pulse.
REQ-047 Scenario 4: timestamp preloaded near 2^CNT_W-5 (force), delay=10 -> fires correctly across the wrap.
REQ-048 Scenario 5: one_shot=1, arm, 2 edges -> 1 pulse and armed=0; cfg_update while busy -> old delay used until idle, new delay applies after.
REQ-049 Scenario 6: rst asserted during a pulse with 2 pending -> trigger_out=0 and pending=0 immediately, and no pulses after release.

Source files
------------

// File: rtl/trigger_delay_pkg.sv
// Shared types for the trigger delay queue.
// Holds the edge-select encoding, the output pulse FSM states and the arm FSM states.
package trigger_delay_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_type_e;

    typedef enum logic {
        OUT_IDLE  = 1'b0,
        OUT_PULSE = 1'b1
    } out_state_e;

    typedef enum logic {
        ARM_DISARMED = 1'b0,
        ARM_ARMED    = 1'b1
    } arm_state_e;

endpackage

// File: rtl/trigger_deadline_fifo.sv
// Deadline FIFO: DEPTH entries of W-bit deadlines, head visible on dout.
// Ports: clk, rst (async high), push/din, pop, dout (head), full, empty, count.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module trigger_deadline_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage is not reset; empty gates every use of the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/trigger_delay_queue.sv
// Trigger delay queue: synchronises an async trigger, detects the selected edge,
// and emits a pulse of programmable width a programmable delay later, with up to
// DEPTH triggers in flight.
// Ports: clk, rst (async high), trigger_in, edge_type, delay_cycles, pulse_width,
// cfg_update, arm, one_shot, clear_overflow -> trigger_out, armed, pending,
// overflow, busy.
module trigger_delay_queue
    import trigger_delay_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned PW_W        = 16,
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trigger_in,
    input  logic [1:0]             edge_type,
    input  logic [CNT_W-1:0]       delay_cycles,
    input  logic [PW_W-1:0]        pulse_width,
    input  logic                   cfg_update,
    input  logic                   arm,
    input  logic                   one_shot,
    input  logic                   clear_overflow,
    output logic                   trigger_out,
    output logic                   armed,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   overflow,
    output logic                   busy
);

    localparam int unsigned PEND_W = $clog2(DEPTH) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   sync_cur;
    logic                   edge_pulse;
    logic                   accept;

    logic [CNT_W-1:0] timestamp;
    logic [CNT_W-1:0] ts_inc;
    logic [CNT_W-1:0] deadline;
    logic [CNT_W-1:0] head;
    logic [CNT_W-1:0] shadow_delay;
    logic [CNT_W-1:0] active_delay;
    logic [PW_W-1:0]  shadow_width;
    logic [PW_W-1:0]  active_width;
    logic [PW_W-1:0]  width_load;
    logic [PW_W-1:0]  width_cnt;
    logic [PW_W-1:0]  width_cnt_next;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fire_q;
    logic              direct_fire;
    logic              fire;
    logic              push;
    logic              push_ok;
    logic              drop;
    logic [PEND_W-1:0] pend_next;
    logic              trigger_out_next;

    out_state_e out_state;
    out_state_e out_state_next;
    arm_state_e arm_state;
    arm_state_e arm_state_next;

    // Input synchroniser plus previous-value register for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], trigger_in};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_cur = sync_q[SYNC_STAGES-1];

    always_comb begin
        edge_pulse = 1'b0;
        case (edge_type_e'(edge_type))
            EDGE_RISE: edge_pulse = sync_cur & ~sync_prev;
            EDGE_FALL: edge_pulse = ~sync_cur & sync_prev;
            EDGE_BOTH: edge_pulse = sync_cur ^ sync_prev;
            default:   edge_pulse = 1'b0;
        endcase
    end

    assign accept = edge_pulse && armed;

    // Free-running timestamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) timestamp <= '0;
        else     timestamp <= timestamp + CNT_W'(1);
    end

    // The head fires in the cycle before its deadline so the registered output
    // rises exactly when timestamp reaches the deadline. A zero delay has to fire
    // in the edge cycle itself, so it bypasses the queue.
    assign ts_inc      = timestamp + CNT_W'(1);
    assign deadline    = timestamp + active_delay + CNT_W'(1);
    assign fire_q      = !fifo_empty && (head == ts_inc);
    assign direct_fire = accept && (active_delay == '0);
    assign fire        = fire_q || direct_fire;
    assign push        = accept && !direct_fire;
    assign push_ok     = push && (!fifo_full || fire_q);
    assign drop        = push && fifo_full && !fire_q;
    assign pend_next   = pending + PEND_W'(push_ok) - PEND_W'(fire_q);

    trigger_deadline_fifo #(
        .DEPTH (DEPTH),
        .W     (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (deadline),
        .pop   (fire_q),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending)
    );

    // Shadow config; active copy only changes while idle so queued deadlines stay ordered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_delay <= '0;
            shadow_width <= PW_W'(1);
            active_delay <= '0;
            active_width <= PW_W'(1);
        end else begin
            if (cfg_update) begin
                shadow_delay <= delay_cycles;
                shadow_width <= pulse_width;
            end
            if (!busy && !accept) begin
                active_delay <= shadow_delay;
                active_width <= shadow_width;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 overflow <= 1'b0;
        else if (drop)           overflow <= 1'b1;
        else if (clear_overflow) overflow <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= 1'b0;
        else     busy <= (pend_next != '0) || trigger_out_next;
    end

    // Output pulse FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_state   <= OUT_IDLE;
            width_cnt   <= '0;
            trigger_out <= 1'b0;
        end else begin
            out_state   <= out_state_next;
            width_cnt   <= width_cnt_next;
            trigger_out <= trigger_out_next;
        end
    end

    assign width_load = (active_width == '0) ? PW_W'(1) : active_width;

    // Output pulse FSM: next state.
    always_comb begin
        out_state_next = out_state;
        case (out_state)
            OUT_IDLE:  if (fire) out_state_next = OUT_PULSE;
            OUT_PULSE: if (!fire && (width_cnt == PW_W'(1))) out_state_next = OUT_IDLE;
            default:   out_state_next = OUT_IDLE;
        endcase
    end

    // Output pulse FSM: outputs. A fire during a pulse reloads and extends it.
    always_comb begin
        width_cnt_next   = width_cnt;
        trigger_out_next = 1'b0;
        case (out_state)
            OUT_IDLE: begin
                if (fire) begin
                    width_cnt_next   = width_load;
                    trigger_out_next = 1'b1;
                end
            end
            OUT_PULSE: begin
                if (fire) begin
                    width_cnt_next   = width_load;
                    trigger_out_next = 1'b1;
                end else if (width_cnt == PW_W'(1)) begin
                    width_cnt_next   = '0;
                    trigger_out_next = 1'b0;
                end else begin
                    width_cnt_next   = width_cnt - PW_W'(1);
                    trigger_out_next = 1'b1;
                end
            end
            default: begin
                width_cnt_next   = '0;
                trigger_out_next = 1'b0;
            end
        endcase
    end

    // Arm FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) arm_state <= ARM_DISARMED;
        else     arm_state <= arm_state_next;
    end

    // Arm FSM: next state. A coincident arm keeps a one-shot armed.
    always_comb begin
        arm_state_next = arm_state;
        case (arm_state)
            ARM_DISARMED: if (arm) arm_state_next = ARM_ARMED;
            ARM_ARMED:    if (one_shot && accept && !arm) arm_state_next = ARM_DISARMED;
            default:      arm_state_next = ARM_DISARMED;
        endcase
    end

    // Arm FSM: outputs.
    always_comb begin
        armed = (arm_state == ARM_ARMED);
    end

endmodule

// File: tb/tb_trigger_delay_queue.sv
module tb_trigger_delay_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned PW_W  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             trigger_in;
    logic [1:0]       edge_type;
    logic [CNT_W-1:0] delay_cycles;
    logic [PW_W-1:0]  pulse_width;
    logic             cfg_update;
    logic             arm;
    logic             one_shot;
    logic             clear_overflow;
    logic             trigger_out;
    logic             armed;
    logic [$clog2(DEPTH):0] pending;
    logic             overflow;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    trigger_delay_queue #(
        .DEPTH       (DEPTH),
        .CNT_W       (CNT_W),
        .PW_W        (PW_W),
        .SYNC_STAGES (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .trigger_in     (trigger_in),
        .edge_type      (edge_type),
        .delay_cycles   (delay_cycles),
        .pulse_width    (pulse_width),
        .cfg_update     (cfg_update),
        .arm            (arm),
        .one_shot       (one_shot),
        .clear_overflow (clear_overflow),
        .trigger_out    (trigger_out),
        .armed          (armed),
        .pending        (pending),
        .overflow       (overflow),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int d, input int w);
        delay_cycles = CNT_W'(d);
        pulse_width  = PW_W'(w);
        cfg_update   = 1'b1;
        tick(1);
        cfg_update   = 1'b0;
        tick(3);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    // With 3 sync stages, trigger_out rises in loop iteration i + delay + 3
    // for an edge driven in iteration i.
    initial begin
        rst            = 1'b1;
        trigger_in     = 1'b0;
        edge_type      = 2'b00;
        delay_cycles   = '0;
        pulse_width    = '0;
        cfg_update     = 1'b0;
        arm            = 1'b0;
        one_shot       = 1'b0;
        clear_overflow = 1'b0;
        tick(2);
        check("rst_out",  64'(trigger_out), 64'd0);
        check("rst_arm",  64'(armed),       64'd0);
        check("rst_pend", 64'(pending),     64'd0);
        check("rst_ovf",  64'(overflow),    64'd0);
        check("rst_busy", 64'(busy),        64'd0);
        rst = 1'b0;
        tick(2);

        // Scenario 1: delay 10, width 3.
        set_cfg(10, 3);
        do_arm();
        check("s1_armed", 64'(armed), 64'd1);
        for (int j = 0; j < 20; j++) begin
            if (j == 0)  trigger_in = 1'b1;
            if (j == 18) trigger_in = 1'b0;
            tick(1);
            check($sformatf("s1_out_%0d", j), 64'(trigger_out), 64'(j >= 13 && j < 16));
            if (j == 5) begin
                check("s1_pend", 64'(pending), 64'd1);
                check("s1_busy", 64'(busy),    64'd1);
            end
        end
        tick(4);
        check("s1_idle", 64'(busy), 64'd0);

        // Scenario 2: overflow with 5 edges, delay 20, width 1.
        set_cfg(20, 1);
        for (int j = 0; j < 36; j++) begin
            if (j < 10) trigger_in = (j % 2 == 0);
            tick(1);
            check($sformatf("s2_out_%0d", j), 64'(trigger_out),
                  64'(j >= 23 && j <= 29 && (j % 2 == 1)));
            if (j == 16) begin
                check("s2_pend", 64'(pending),  64'd4);
                check("s2_ovf",  64'(overflow), 64'd1);
            end
        end
        check("s2_pend_end", 64'(pending),  64'd0);
        check("s2_ovf_end",  64'(overflow), 64'd1);
        clear_overflow = 1'b1;
        tick(1);
        clear_overflow = 1'b0;
        check("s2_ovf_clr", 64'(overflow), 64'd0);

        // Scenario 3: delay 0, width 0 -> single cycle pulse.
        set_cfg(0, 0);
        for (int j = 0; j < 8; j++) begin
            if (j == 0) trigger_in = 1'b1;
            tick(1);
            check($sformatf("s3_out_%0d", j), 64'(trigger_out), 64'(j == 3));
        end

        // Falling edge select, width 2.
        edge_type = 2'b01;
        set_cfg(0, 2);
        for (int j = 0; j < 8; j++) begin
            if (j == 0) trigger_in = 1'b0;
            tick(1);
            check($sformatf("fall_out_%0d", j), 64'(trigger_out), 64'(j == 3 || j == 4));
        end

        // No edge selected.
        edge_type = 2'b11;
        for (int j = 0; j < 12; j++) begin
            if (j == 0) trigger_in = 1'b1;
            if (j == 5) trigger_in = 1'b0;
            tick(1);
            check($sformatf("none_out_%0d", j), 64'(trigger_out), 64'd0);
        end

        // Both edges.
        edge_type = 2'b10;
        for (int j = 0; j < 14; j++) begin
            if (j == 0) trigger_in = 1'b1;
            if (j == 6) trigger_in = 1'b0;
            tick(1);
            check($sformatf("both_out_%0d", j), 64'(trigger_out),
                  64'(j == 3 || j == 4 || j == 9 || j == 10));
        end
        edge_type = 2'b00;

        // Scenario 4: timestamp wrap.
        set_cfg(10, 2);
        @(posedge clk);
        #1;
        force dut.timestamp = 32'hFFFF_FFFB;
        @(negedge clk);
        release dut.timestamp;
        for (int j = 0; j < 18; j++) begin
            if (j == 0)  trigger_in = 1'b1;
            if (j == 16) trigger_in = 1'b0;
            tick(1);
            if (j == 0) check("s4_ts", 64'(dut.timestamp), 64'hFFFF_FFFC);
            check($sformatf("s4_out_%0d", j), 64'(trigger_out), 64'(j >= 13 && j < 15));
        end

        // Scenario 5: one-shot and deferred config.
        do_reset();
        one_shot = 1'b1;
        set_cfg(5, 1);
        do_arm();
        check("s5_armed", 64'(armed), 64'd1);
        for (int j = 0; j < 17; j++) begin
            if (j == 0) trigger_in = 1'b1;
            if (j == 2) trigger_in = 1'b0;
            if (j == 4) trigger_in = 1'b1;
            if (j == 8) trigger_in = 1'b0;
            if (j == 5) delay_cycles = CNT_W'(2);
            cfg_update = (j == 5);
            tick(1);
            check($sformatf("s5_out_%0d", j), 64'(trigger_out), 64'(j == 8));
            if (j == 6) check("s5_disarm", 64'(armed), 64'd0);
        end
        for (int j = 0; j < 11; j++) begin
            arm = (j == 0);
            if (j == 1) trigger_in = 1'b1;
            tick(1);
            check($sformatf("s5b_out_%0d", j), 64'(trigger_out), 64'(j == 6));
        end
        check("s5b_disarm", 64'(armed), 64'd0);

        // Scenario 6: reset mid-pulse with two pending.
        trigger_in = 1'b0;
        do_reset();
        one_shot = 1'b0;
        set_cfg(10, 4);
        do_arm();
        for (int j = 0; j < 14; j++) begin
            if (j < 6) trigger_in = (j % 2 == 0);
            tick(1);
            check($sformatf("s6_out_%0d", j), 64'(trigger_out), 64'(j >= 13));
        end
        check("s6_pend_pre", 64'(pending), 64'd2);
        rst = 1'b1;
        #1;
        check("s6_rst_out",  64'(trigger_out), 64'd0);
        check("s6_rst_pend", 64'(pending),     64'd0);
        check("s6_rst_busy", 64'(busy),        64'd0);
        check("s6_rst_arm",  64'(armed),       64'd0);
        tick(2);
        rst = 1'b0;
        for (int j = 0; j < 30; j++) begin
            tick(1);
            check($sformatf("s6_post_%0d", j), 64'(trigger_out), 64'd0);
        end
        check("s6_pend_end", 64'(pending), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
